data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-port round-robin arbiter that shares the single-port data memory of the single-cycle core between the core's load/store path (requester 0) and a loader/debug port (requester 1). It sequences one memory access per cycle, routes read data back to the requester that issued the access, enforces a grant lock for atomic loader bursts, and rejects misaligned or out-of-range addresses without touching memory. It sits between the core and `data_memory`, replacing the direct core-to-memory connection.

## Interface
- `ADDR_WIDTH`, 32: byte-address width on requester ports.
- `DATA_WIDTH`, 32: data word width.
- `MEM_WORDS`, 1024: memory depth in words. Word index = `addr[ADDR_WIDTH-1:2]`.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `reqN_valid`  in  1  requester N (N = 0, 1) has an access pending.
- `reqN_ready`  out  1  access accepted this cycle when `reqN_valid && reqN_ready`.
- `reqN_write`  in  1  1 = store, 0 = load.
- `reqN_lock`  in  1  hold the grant while asserted (see Operation).
- `reqN_addr`  in  ADDR_WIDTH  byte address.
- `reqN_wdata`  in  DATA_WIDTH  store data.
- `reqN_rvalid`  out  1  one-cycle pulse: load data valid.
- `reqN_rdata`  out  DATA_WIDTH  load data; 0 when `reqN_rvalid` = 0.
- `reqN_err`  out  1  one-cycle pulse: access rejected.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable (qualified by `mem_en`).
- `mem_addr`  out  clog2(MEM_WORDS)  word index.
- `mem_wdata`  out  DATA_WIDTH  write data.
- `mem_rdata`  in  DATA_WIDTH  read data, valid the cycle after a read `mem_en` (synchronous memory).

## Operation
- State: `rr_last` (index of last granted requester), `lock_owner_valid`/`lock_owner`, response registers `resp_valid`, `resp_owner`, `resp_is_err`, `resp_is_read`.
- Grant (combinational, one requester per cycle):
  - If a lock is held and the owner's `valid` = 1: owner wins.
  - Else if only one `valid`: it wins.
  - Else if both: requester ≠ `rr_last` wins.
- `reqN_ready` = 1 only for the granted requester; never both. Ready is never asserted without `valid`.
- On accept: `rr_last` ← granted index.
- Address check: legal iff `addr[1:0]` = 0 and word index < MEM_WORDS.
  - Legal: `mem_en` = 1, `mem_we` = `write`, `mem_addr`/`mem_wdata` driven from the winner in the same cycle.
  - Illegal: `mem_en` = 0; an error response is scheduled.
- Lock: sampled on an accepted access. `lock` = 1 sets `lock_owner` to the winner. An accepted access with `lock` = 0 releases it. The lock also releases if the owner drops `valid` for a cycle.
- Responses:
  - Legal loads: `rvalid` pulse next cycle with `rdata` = `mem_rdata`.
  - Legal stores: no response.
  - Illegal accesses (load or store): `err` pulse next cycle, with `rvalid` = 0.

## Timing
- Reset (`reset` = 0, asynchronous) forces all outputs to 0: `ready`, `rvalid`, `rdata`, `err`, all `mem_*`. Registers clear to `rr_last` = 1 (requester 0 wins the first tie) and lock released.
- Accept-to-response latency is 1 cycle. Throughput is one access per cycle, back-to-back. A response and a new accept may coincide, for the same or the other requester.
- A store followed immediately by a load to the same word returns the new data (memory write-before-read ordering).
- Reset asserted mid-operation clears any pending response immediately. No `rvalid`/`err` pulse appears after reset deasserts.
- Requester inputs may change freely while not accepted; the arbiter does not register request data.
- No starvation without lock: with both valid, grants strictly alternate.

## Test plan
- Reset: hold `reset` = 0 for 2 cycles with both valid → every output 0. Release → first tie granted to requester 0.
- Single load: preload memory word 2 = 20. Req0 reads addr 0x8 → `mem_en` = 1, `mem_addr` = 2 in the accept cycle. Next cycle `req0_rvalid` = 1, `req0_rdata` = 0x14.
- Contention: both requesters issue stores continuously for 6 cycles → grants 0,1,0,1,0,1. Memory words hold the last written values.
- Lock: req1 writes words 0–2 with `lock` = 1, then `lock` = 0 on the last, while req0 is valid throughout → grants 1,1,1,0.
- Errors: req0 loads 0x6 → `mem_en` = 0, then `req0_err` pulse, `req0_rvalid` = 0. Req1 stores to word MEM_WORDS → `req1_err` pulse, memory unchanged.
- Reset mid-load: assert `reset` in the cycle after a legal read accept → `req0_rvalid` drops immediately. No pulse after release.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin arbiter with a grant lock that shares a
// single-port synchronous data memory between the core (req0) and a
// loader/debug port (req1). Misaligned or out-of-range accesses are rejected
// with an error pulse and never reach the memory.
module data_memory_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic                         req0_write,
  input  logic                         req0_lock,
  input  logic [ADDR_WIDTH-1:0]        req0_addr,
  input  logic [DATA_WIDTH-1:0]        req0_wdata,
  output logic                         req0_rvalid,
  output logic [DATA_WIDTH-1:0]        req0_rdata,
  output logic                         req0_err,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic                         req1_write,
  input  logic                         req1_lock,
  input  logic [ADDR_WIDTH-1:0]        req1_addr,
  input  logic [DATA_WIDTH-1:0]        req1_wdata,
  output logic                         req1_rvalid,
  output logic [DATA_WIDTH-1:0]        req1_rdata,
  output logic                         req1_err,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int unsigned MEM_AW = $clog2(MEM_WORDS);
  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;

  // Arbitration and lock state
  logic r_rr_last;
  logic r_lock_valid;
  logic r_lock_owner;

  // Pending one-cycle response
  logic r_resp_valid;
  logic r_resp_owner;
  logic r_resp_is_err;
  logic r_resp_is_read;

  logic [1:0]            w_valid;
  logic                  w_gnt_valid;
  logic                  w_gnt;
  logic                  w_write;
  logic                  w_lock;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_legal;
  logic                  w_mem_go;
  logic                  w_rsp_read;
  logic                  w_rsp_err;

  assign w_valid = {req1_valid, req0_valid};

  // Grant selection: lock owner first, then single requester, then round-robin
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = 1'b0;
    if (reset) begin
      if (r_lock_valid && w_valid[r_lock_owner]) begin
        w_gnt_valid = 1'b1;
        w_gnt       = r_lock_owner;
      end else if (req0_valid && req1_valid) begin
        w_gnt_valid = 1'b1;
        w_gnt       = ~r_rr_last;
      end else if (req0_valid) begin
        w_gnt_valid = 1'b1;
        w_gnt       = 1'b0;
      end else if (req1_valid) begin
        w_gnt_valid = 1'b1;
        w_gnt       = 1'b1;
      end
    end
  end

  // Winner's request fields
  assign w_write = w_gnt ? req1_write : req0_write;
  assign w_lock  = w_gnt ? req1_lock  : req0_lock;
  assign w_addr  = w_gnt ? req1_addr  : req0_addr;
  assign w_wdata = w_gnt ? req1_wdata : req0_wdata;

  assign w_legal  = (w_addr[1:0] == 2'b00) &&
                    (w_addr[ADDR_WIDTH-1:2] < IDX_W'(MEM_WORDS));
  assign w_mem_go = w_gnt_valid && w_legal;

  assign req0_ready = w_gnt_valid && !w_gnt;
  assign req1_ready = w_gnt_valid &&  w_gnt;

  assign mem_en    = w_mem_go;
  assign mem_we    = w_mem_go && w_write;
  assign mem_addr  = w_mem_go ? w_addr[MEM_AW+1:2] : '0;
  assign mem_wdata = w_mem_go ? w_wdata : '0;

  assign w_rsp_read = r_resp_valid && r_resp_is_read && !r_resp_is_err;
  assign w_rsp_err  = r_resp_valid && r_resp_is_err;

  assign req0_rvalid = w_rsp_read && !r_resp_owner;
  assign req1_rvalid = w_rsp_read &&  r_resp_owner;
  assign req0_rdata  = req0_rvalid ? mem_rdata : '0;
  assign req1_rdata  = req1_rvalid ? mem_rdata : '0;
  assign req0_err    = w_rsp_err && !r_resp_owner;
  assign req1_err    = w_rsp_err &&  r_resp_owner;

  // Round-robin pointer, lock ownership and response scheduling
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_last      <= 1'b1;
      r_lock_valid   <= 1'b0;
      r_lock_owner   <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_owner   <= 1'b0;
      r_resp_is_err  <= 1'b0;
      r_resp_is_read <= 1'b0;
    end else begin
      // Legal stores produce no response; loads and rejects respond next cycle
      r_resp_valid   <= w_gnt_valid && (!w_legal || !w_write);
      r_resp_owner   <= w_gnt;
      r_resp_is_err  <= !w_legal;
      r_resp_is_read <= !w_write;
      if (w_gnt_valid) begin
        r_rr_last    <= w_gnt;
        r_lock_valid <= w_lock;
        r_lock_owner <= w_gnt;
      end else if (r_lock_valid && !w_valid[r_lock_owner]) begin
        r_lock_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: synchronous memory model, a behavioural
// reference checked every cycle, directed scenarios and a random phase.
module tb_data_memory_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 1024;
  localparam int unsigned MA = $clog2(MW);

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req0_write, req0_lock;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req0_rvalid, req0_err;
  logic          req1_valid, req1_ready, req1_write, req1_lock;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic          req1_rvalid, req1_err;
  logic          mem_en, mem_we;
  logic [MA-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int passed = 0;

  data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous single-port memory
  logic [DW-1:0] mem [MW];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Reference model state
  logic [DW-1:0] m_mem [MW];
  int            m_last = 1;
  int            m_lock = -1;
  bit            p_valid = 1'b0;
  int            p_owner = 0;
  bit            p_err = 1'b0;
  logic [DW-1:0] p_data = '0;
  int            g_hist[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Per-cycle comparison against the reference model
  always @(negedge clock) begin : cmp
    int            g;
    bit            v [2];
    bit            wr [2];
    bit            lk [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    bit            legal;
    int            idx;
    bit            e_rv0, e_rv1, e_er0, e_er1;
    logic [DW-1:0] e_rd0, e_rd1;
    if (!reset) begin
      chk("reset_ctrl", {req0_ready, req1_ready, req0_rvalid, req1_rvalid,
                         req0_err, req1_err, mem_en, mem_we}, 64'd0);
      chk("reset_rdata", {req0_rdata, req1_rdata}, 64'd0);
      chk("reset_mem", {mem_addr, mem_wdata}, 64'd0);
      m_last  = 1;
      m_lock  = -1;
      p_valid = 1'b0;
    end else begin
      v[0] = req0_valid; wr[0] = req0_write; lk[0] = req0_lock; a[0] = req0_addr; d[0] = req0_wdata;
      v[1] = req1_valid; wr[1] = req1_write; lk[1] = req1_lock; a[1] = req1_addr; d[1] = req1_wdata;
      // Responses scheduled last cycle
      e_rv0 = p_valid && !p_err && p_owner == 0;
      e_rv1 = p_valid && !p_err && p_owner == 1;
      e_er0 = p_valid &&  p_err && p_owner == 0;
      e_er1 = p_valid &&  p_err && p_owner == 1;
      e_rd0 = e_rv0 ? p_data : '0;
      e_rd1 = e_rv1 ? p_data : '0;
      chk("rsp_flags", {req0_rvalid, req1_rvalid, req0_err, req1_err},
          {60'd0, e_rv0, e_rv1, e_er0, e_er1});
      chk("rdata0", req0_rdata, e_rd0);
      chk("rdata1", req1_rdata, e_rd1);
      // Who wins this cycle
      if (m_lock >= 0 && v[m_lock]) g = m_lock;
      else if (v[0] && v[1])        g = (m_last == 0) ? 1 : 0;
      else if (v[0])                g = 0;
      else if (v[1])                g = 1;
      else                          g = -1;
      chk("ready", {req1_ready, req0_ready}, (g == 1) ? 64'd2 : (g == 0) ? 64'd1 : 64'd0);
      legal = 1'b0;
      idx   = 0;
      if (g >= 0) begin
        legal = (a[g] % 4 == 0) && ((a[g] / 4) < MW);
        idx   = int'(a[g] / 4);
      end
      if (g >= 0 && legal) begin
        chk("mem_en_we", {mem_en, mem_we}, {62'd0, 1'b1, wr[g]});
        chk("mem_addr", mem_addr, idx);
        if (wr[g]) chk("mem_wdata", mem_wdata, d[g]);
      end else begin
        chk("mem_idle", {mem_en, mem_we}, 64'd0);
      end
      // Advance model to the next cycle
      p_valid = 1'b0;
      if (g >= 0) begin
        g_hist.push_back(g);
        m_last  = g;
        m_lock  = lk[g] ? g : -1;
        p_owner = g;
        if (!legal) begin
          p_valid = 1'b1;
          p_err   = 1'b1;
        end else if (!wr[g]) begin
          p_valid = 1'b1;
          p_err   = 1'b0;
          p_data  = m_mem[idx];
        end else begin
          m_mem[idx] = d[g];
        end
      end else if (m_lock >= 0 && !v[m_lock]) begin
        m_lock = -1;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req0_write = 1'b0; req0_lock = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_lock = 1'b0; req1_addr = '0; req1_wdata = '0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0)      return AW'(MW * 4 + ($urandom_range(0, 255) << 2));
    else if (r == 1) return AW'(($urandom_range(0, 15) << 2) | $urandom_range(1, 3));
    else if (r == 2) return AW'($urandom);
    else             return AW'($urandom_range(0, 15) << 2);
  endfunction

  function automatic int hist_at(input int i);
    if (i < g_hist.size()) return g_hist[i];
    return -1;
  endfunction

  initial begin
    int n0, n1, i;
    bit r0, r1, done0;
    int exp_c [6];
    int exp_l [4];
    exp_c = '{0, 1, 0, 1, 0, 1};
    exp_l = '{1, 1, 1, 0};
    for (int k = 0; k < int'(MW); k++) begin
      mem[k]   = '0;
      m_mem[k] = '0;
    end
    mem[2]   = 32'd20;
    m_mem[2] = 32'd20;
    reset = 1'b0;
    idle();
    req0_valid = 1'b1;
    req1_valid = 1'b1;

    // Reset held with both valid, then first tie
    repeat (2) step();
    reset = 1'b1;
    @(negedge clock);
    chk("first_tie", {req1_ready, req0_ready}, 64'd1);
    step();
    idle();
    step();

    // Single load of word 2
    req0_valid = 1'b1; req0_addr = 32'h8;
    @(negedge clock);
    chk("load_strobe", {mem_en, mem_we, 22'd0, mem_addr}, {1'b1, 1'b0, 22'd0, 10'd2});
    step();
    idle();
    @(negedge clock);
    chk("load_data", {req0_rvalid, req0_rdata}, {1'b1, 32'h14});
    step();
    req1_valid = 1'b1; req1_addr = 32'h8;
    step();
    idle();
    step();

    // Contention: both storing continuously
    g_hist.delete();
    n0 = 0; n1 = 0;
    for (int c = 0; c < 6; c++) begin
      req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'd16; req0_wdata = DW'(100 + n0);
      req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'd20; req1_wdata = DW'(200 + n1);
      @(negedge clock);
      r0 = req0_ready; r1 = req1_ready;
      step();
      if (r0) n0++;
      if (r1) n1++;
    end
    idle();
    step();
    chk("contention_count", g_hist.size(), 6);
    for (int k = 0; k < 6; k++) chk($sformatf("contention_grant%0d", k), hist_at(k), exp_c[k]);
    chk("contention_mem4", mem[4], 102);
    chk("contention_mem5", mem[5], 202);

    // Locked burst by req1 while req0 waits
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'd28; req0_wdata = 32'd7;
    step();
    idle();
    g_hist.delete();
    i = 0; done0 = 1'b0;
    for (int c = 0; c < 8 && (i < 3 || !done0); c++) begin
      req1_valid = (i < 3); req1_write = 1'b1; req1_lock = (i < 2);
      req1_addr = AW'(i * 4); req1_wdata = DW'(300 + i);
      req0_valid = !done0; req0_write = 1'b1; req0_lock = 1'b0;
      req0_addr = 32'd24; req0_wdata = 32'd400;
      @(negedge clock);
      r0 = req0_ready; r1 = req1_ready;
      step();
      if (r1) i++;
      if (r0) done0 = 1'b1;
    end
    idle();
    step();
    chk("lock_count", g_hist.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("lock_grant%0d", k), hist_at(k), exp_l[k]);
    chk("lock_mem", {mem[0], mem[2]}, {32'd300, 32'd302});
    chk("lock_mem6", mem[6], 400);

    // Rejected accesses
    req0_valid = 1'b1; req0_addr = 32'h6;
    @(negedge clock);
    chk("misalign_no_mem", mem_en, 0);
    step();
    idle();
    @(negedge clock);
    chk("misalign_err", {req0_err, req0_rvalid}, 64'd2);
    step();
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = AW'(MW * 4); req1_wdata = 32'hdead;
    @(negedge clock);
    chk("range_no_mem", mem_en, 0);
    step();
    idle();
    @(negedge clock);
    chk("range_err", {req1_err, req1_rvalid}, 64'd2);
    chk("range_mem0", mem[0], 300);
    step();

    // Reset in the cycle after a load accept
    req0_valid = 1'b1; req0_addr = 32'h8;
    step();
    reset = 1'b0;
    idle();
    @(negedge clock);
    chk("reset_kills_rvalid", req0_rvalid, 0);
    step();
    reset = 1'b1;
    @(negedge clock);
    chk("no_pulse_after_reset", {req0_rvalid, req1_rvalid, req0_err, req1_err}, 64'd0);
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) != 0);
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_write = $urandom_range(0, 1) == 1;
      req0_lock  = ($urandom_range(0, 3) == 0);
      req0_addr  = rnd_addr();
      req0_wdata = $urandom;
      req1_valid = ($urandom_range(0, 2) != 0);
      req1_write = $urandom_range(0, 1) == 1;
      req1_lock  = ($urandom_range(0, 2) == 0);
      req1_addr  = rnd_addr();
      req1_wdata = $urandom;
      step();
    end
    reset = 1'b1;
    idle();
    step();
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
